seg7_scan_capture: RTL and testbench

Capture block for time-multiplexed 7-segment display buses. It samples the shared segment lines and one-hot digit-select lines of an NUM_DIGITS-digit scanned display, and accepts a segment pattern once it has been stable long enough. Each accepted pattern is decoded back to its 4-bit hex value. Digits are assembled into a full frame, which is delivered over a valid/ready handshake. The block sits on the observe/self-check side of the display path and inverts the binary-to-segment decoder.

---
 rtl/seg7_scan_capture.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: observes a time-multiplexed 7-segment display bus,
// waits for each (segments, digit-select) pair to settle, decodes the glyph
// back to its hex value and assembles the digits into frames that are handed
// off over a valid/ready interface.
module seg7_scan_capture #(
  parameter bit seg_type      = 1'b1,
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] data_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    overrun,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [6:0] SEG_IDLE     = seg_type ? 7'h7F : 7'h00;
  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  typedef enum logic {
    COUNT = 1'b0,
    HELD  = 1'b1
  } cap_state_t;

  logic [6:0]              seg_s1;
  logic [6:0]              seg_s2;
  logic [6:0]              seg_prev;
  logic [NUM_DIGITS-1:0]   dig_s1;
  logic [NUM_DIGITS-1:0]   dig_s2;
  logic [NUM_DIGITS-1:0]   dig_prev;

  logic [6:0]              seg_norm;
  logic [3:0]              dig_ones;
  logic                    dig_one_hot;
  logic                    pair_changed;
  logic                    capture;
  logic [3:0]              dec_val;
  logic                    dec_err;

  cap_state_t              state;
  logic [7:0]              run_cnt;

  logic [4*NUM_DIGITS-1:0] data_asm;
  logic [NUM_DIGITS-1:0]   err_asm;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   mask_nxt;
  logic                    asm_ovr;
  logic                    asm_ovr_nxt;
  logic                    frame_full;
  logic                    load_frame;

  // Inverse of the hex-to-segment encoder; bit 4 flags an illegal glyph.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = 5'h00;
      7'h06:   res = 5'h01;
      7'h5B:   res = 5'h02;
      7'h4F:   res = 5'h03;
      7'h66:   res = 5'h04;
      7'h6D:   res = 5'h05;
      7'h7D:   res = 5'h06;
      7'h07:   res = 5'h07;
      7'h7F:   res = 5'h08;
      7'h6F:   res = 5'h09;
      7'h77:   res = 5'h0A;
      7'h7C:   res = 5'h0B;
      7'h39:   res = 5'h0C;
      7'h5E:   res = 5'h0D;
      7'h79:   res = 5'h0E;
      7'h71:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  // Two-flop synchronizers plus a copy of the previous synchronized pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1   <= SEG_IDLE;
      seg_s2   <= SEG_IDLE;
      seg_prev <= SEG_IDLE;
      dig_s1   <= '0;
      dig_s2   <= '0;
      dig_prev <= '0;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      dig_s1   <= dig_sel;
      dig_s2   <= dig_s1;
      dig_prev <= dig_s2;
    end
  end

  // Normalize polarity, qualify the digit select and decide whether to capture.
  always_comb begin
    seg_norm = seg_type ? ~seg_s2 : seg_s2;
    {dec_err, dec_val} = decode_glyph(seg_norm);
    dig_ones = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_ones = dig_ones + {3'b000, dig_s2[k]};
    end
    dig_one_hot  = (dig_ones == 4'd1);
    pair_changed = (seg_s2 != seg_prev) || (dig_s2 != dig_prev);
    capture      = dig_one_hot && !pair_changed && (state == COUNT) &&
                   ((run_cnt + 8'd1) == STABLE_LIMIT);
  end

  // Stability run counter and COUNT/HELD capture state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COUNT;
      run_cnt <= 8'd0;
    end else if (!dig_one_hot) begin
      state   <= COUNT;
      run_cnt <= 8'd0;
    end else if (pair_changed) begin
      state   <= COUNT;
      run_cnt <= 8'd1;
    end else if (state == COUNT) begin
      run_cnt <= run_cnt + 8'd1;
      if (capture) begin
        state <= HELD;
      end
    end
  end

  // Next mask and sticky overwrite flag, accounting for a same-edge hand-off.
  always_comb begin
    frame_full  = &mask;
    load_frame  = frame_full && (!out_valid || out_ready);
    mask_nxt    = load_frame ? '0 : mask;
    asm_ovr_nxt = load_frame ? 1'b0 : asm_ovr;
    if (capture) begin
      mask_nxt = mask_nxt | dig_s2;
      if (!load_frame && ((mask & dig_s2) != '0)) begin
        asm_ovr_nxt = 1'b1;
      end
    end
  end

  // Assembly slots and the output register with its valid/ready hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_asm  <= '0;
      err_asm   <= '0;
      mask      <= '0;
      asm_ovr   <= 1'b0;
      data_out  <= '0;
      err_out   <= '0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      mask    <= mask_nxt;
      asm_ovr <= asm_ovr_nxt;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && dig_s2[k]) begin
          data_asm[4*k +: 4] <= dec_val;
          err_asm[k]         <= dec_err;
        end
      end
      if (load_frame) begin
        data_out  <= data_asm;
        err_out   <= err_asm;
        overrun   <= asm_ovr;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed scan sequences for seg7_scan_capture; expected
// frames are queued as stimulus is issued and a monitor checks each hand-off.
module tb_seg7_scan_capture;

  localparam int NUM_DIGITS    = 4;
  localparam int STABLE_CYCLES = 4;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  err;
    logic        ovr;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] data_out;
  logic [3:0]  err_out;
  logic        overrun;
  logic        out_valid;
  logic        out_ready;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_capture #(
    .seg_type      (1'b1),
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .data_out  (data_out),
    .err_out   (err_out),
    .overrun   (overrun),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Active-low bus encoding of a hex digit.
  function automatic logic [6:0] encDigit(input logic [3:0] v);
    logic [6:0] g;
    g = glyph[v];
    return ~g;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] dig, input int cycles);
    seg_in  = seg;
    dig_sel = dig;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scanDigit(input int idx, input logic [3:0] val);
    applyStimulus(encDigit(val), 4'(1 << idx), 8);
  endtask

  task automatic scanFrame(input logic [15:0] frame);
    for (int k = 0; k < 4; k++) begin
      scanDigit(k, frame[4*k +: 4]);
    end
  endtask

  task automatic idle(input int cycles);
    applyStimulus(7'h7F, 4'b0000, cycles);
  endtask

  task automatic expectBeat(input logic [15:0] d, input logic [3:0] e, input logic o);
    beat_t b;
    b.data = d;
    b.err  = e;
    b.ovr  = o;
    exp_q.push_back(b);
  endtask

  // Monitor: every accepted beat is compared against the oldest queued frame.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_beat: got data 0x%0h err 0x%0h ovr %0b, expected no beat",
                 data_out, err_out, overrun);
      end else begin
        e = exp_q.pop_front();
        checkOutput("beat_data", 32'(data_out), 32'(e.data));
        checkOutput("beat_err",  32'(err_out),  32'(e.err));
        checkOutput("beat_ovr",  32'(overrun),  32'(e.ovr));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios.
  initial begin
    rst       = 1'b1;
    seg_in    = 7'h7F;
    dig_sel   = 4'b0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_valid",   32'(out_valid), 32'd0);
    checkOutput("reset_data",    32'(data_out),  32'd0);
    checkOutput("reset_err",     32'(err_out),   32'd0);
    checkOutput("reset_overrun", 32'(overrun),   32'd0);
    idle(3);

    $display("[TB] basic frame");
    expectBeat(16'h4321, 4'b0000, 1'b0);
    applyStimulus(7'h79, 4'b0001, 8);
    applyStimulus(7'h24, 4'b0010, 8);
    applyStimulus(7'h30, 4'b0100, 8);
    applyStimulus(7'h19, 4'b1000, 8);
    idle(6);

    $display("[TB] glyph sweep");
    expectBeat(16'h3210, 4'b0000, 1'b0);
    scanFrame(16'h3210);
    expectBeat(16'h7654, 4'b0000, 1'b0);
    scanFrame(16'h7654);
    expectBeat(16'hBA98, 4'b0000, 1'b0);
    scanFrame(16'hBA98);
    expectBeat(16'hFEDC, 4'b0000, 1'b0);
    scanFrame(16'hFEDC);
    idle(6);

    $display("[TB] glitch rejection");
    expectBeat(16'h0008, 4'b0000, 1'b0);
    applyStimulus(encDigit(4'h5), 4'b0001, 3);
    applyStimulus(encDigit(4'h8), 4'b0001, 8);
    scanDigit(1, 4'h0);
    scanDigit(2, 4'h0);
    scanDigit(3, 4'h0);
    idle(6);

    $display("[TB] blank digit");
    expectBeat(16'h1011, 4'b0100, 1'b0);
    scanDigit(0, 4'h1);
    scanDigit(1, 4'h1);
    applyStimulus(7'h7F, 4'b0100, 8);
    scanDigit(3, 4'h1);
    idle(6);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    expectBeat(16'h4321, 4'b0000, 1'b0);
    expectBeat(16'h8769, 4'b0000, 1'b1);
    scanFrame(16'h4321);
    idle(3);
    checkOutput("bp_valid_first", 32'(out_valid), 32'd1);
    checkOutput("bp_data_first",  32'(data_out),  32'h4321);
    scanFrame(16'h8765);
    scanDigit(0, 4'h9);
    idle(3);
    checkOutput("bp_valid_held",   32'(out_valid), 32'd1);
    checkOutput("bp_data_held",    32'(data_out),  32'h4321);
    checkOutput("bp_overrun_held", 32'(overrun),   32'd0);
    out_ready = 1'b1;
    idle(8);
    checkOutput("bp_valid_after", 32'(out_valid), 32'd0);

    $display("[TB] reset mid-frame");
    scanDigit(0, 4'h6);
    scanDigit(1, 4'h7);
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_valid",   32'(out_valid), 32'd0);
    checkOutput("midrst_data",    32'(data_out),  32'd0);
    checkOutput("midrst_err",     32'(err_out),   32'd0);
    checkOutput("midrst_overrun", 32'(overrun),   32'd0);
    scanDigit(2, 4'h2);
    scanDigit(3, 4'h3);
    idle(10);
    checkOutput("midrst_no_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_data_end", 32'(data_out),  32'd0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
